// File: rtl/newton_iter_sched_pkg.sv
// Shared FP-unit definitions: op encoding, scheduler states and the engine's default latency.
package newton_iter_sched_pkg;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;

    // Newton engine runs 3 iterations x 7 cycles plus one result cycle.
    localparam int ITER_CYCLES_DEF = 22;
    localparam int CNT_W           = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/newton_iter_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the op opposite the one just completed.
module rr_arb2
    import newton_iter_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (r_ptr == OP_SQRT) ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= OP_DIV;
        end else if (i_upd) begin
            r_ptr <= ~i_last;
        end
    end

endmodule

// File: rtl/newton_iter_sched.sv
// Shares one Newton-Raphson divide/sqrt engine between two requesters: arbitrate, start, time, hold result.
module newton_iter_sched
    import newton_iter_sched_pkg::*;
#(
    parameter int ITER_CYCLES = ITER_CYCLES_DEF,
    parameter int W           = 24
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         div_req,
    input  logic [W-1:0] div_a,
    input  logic [W-1:0] div_b,
    input  logic         sqrt_req,
    input  logic [W-1:0] sqrt_d,
    input  logic         cancel,
    output logic         div_ack,
    output logic         sqrt_ack,
    output logic         div_stall,
    output logic         sqrt_stall,
    output logic         eng_start,
    output logic         eng_op,
    output logic [W-1:0] eng_a,
    output logic [W-1:0] eng_b,
    input  logic [31:0]  eng_q,
    output logic         res_valid,
    output logic         res_op,
    output logic [31:0]  res_q,
    input  logic         res_ready,
    output logic         busy,
    output logic [4:0]   count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_count;
    logic             r_eng_start;
    logic             r_eng_op;
    logic [W-1:0]     r_eng_a;
    logic [W-1:0]     r_eng_b;
    logic             r_res_valid;
    logic             r_res_op;
    logic [31:0]      r_res_q;
    logic             w_arb_en;
    logic             w_ptr_upd;
    logic [1:0]       w_gnt;
    logic             w_grant;
    logic             w_win_op;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (clrn),
        .i_en   (w_arb_en),
        .i_req  ({sqrt_req, div_req}),
        .i_upd  (w_ptr_upd),
        .i_last (r_eng_op),
        .o_gnt  (w_gnt)
    );

    assign w_grant  = |w_gnt;
    assign w_win_op = w_gnt[1] ? OP_SQRT : OP_DIV;

    always_comb begin
        w_state_nx = r_state;
        w_arb_en   = 1'b0;
        w_ptr_upd  = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb_en = ~cancel & ~clrn;
                if (w_grant) w_state_nx = RUN;
            end
            RUN: begin
                if (cancel)                    w_state_nx = IDLE;
                else if (r_count == CNT_LAST)  w_state_nx = DONE;
            end
            DONE: begin
                // A flush beats acceptance: the result is dropped and priority stays put.
                if (cancel) begin
                    w_state_nx = IDLE;
                end else if (res_ready) begin
                    w_state_nx = IDLE;
                    w_ptr_upd  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrn) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_count     <= '0;
            r_eng_start <= 1'b0;
            r_eng_op    <= OP_DIV;
            r_eng_a     <= '0;
            r_eng_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_op    <= OP_DIV;
            r_res_q     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_eng_op    <= w_win_op;
                        r_eng_a     <= (w_win_op == OP_SQRT) ? sqrt_d : div_a;
                        r_eng_b     <= (w_win_op == OP_SQRT) ? '0 : div_b;
                        r_eng_start <= 1'b1;
                        r_count     <= CNT_W'(1);
                    end
                end
                RUN: begin
                    r_eng_start <= 1'b0;
                    if (cancel) begin
                        r_count <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_res_q     <= eng_q;
                        r_res_op    <= r_eng_op;
                        r_res_valid <= 1'b1;
                        r_count     <= '0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (cancel || res_ready) r_res_valid <= 1'b0;
                end
                default: begin
                    r_count     <= '0;
                    r_eng_start <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign div_ack    = w_gnt[0];
    assign sqrt_ack   = w_gnt[1];
    assign busy       = (r_state != IDLE);
    assign div_stall  = (div_req & ~div_ack)   | (busy & (r_eng_op == OP_DIV));
    assign sqrt_stall = (sqrt_req & ~sqrt_ack) | (busy & (r_eng_op == OP_SQRT));
    assign eng_start  = r_eng_start;
    assign eng_op     = r_eng_op;
    assign eng_a      = r_eng_a;
    assign eng_b      = r_eng_b;
    assign res_valid  = r_res_valid;
    assign res_op     = r_res_op;
    assign res_q      = r_res_q;
    assign count      = r_count;

endmodule

// File: tb/tb_newton_iter_sched.sv
// Bench for newton_iter_sched: directed scenarios with literal checks plus a cycle-level reference model.
module tb_newton_iter_sched;

    localparam int ITER = 22;
    localparam int W    = 24;

    logic         clk;
    logic         clrn;
    logic         div_req;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         sqrt_req;
    logic [W-1:0] sqrt_d;
    logic         cancel;
    logic         div_ack;
    logic         sqrt_ack;
    logic         div_stall;
    logic         sqrt_stall;
    logic         eng_start;
    logic         eng_op;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;
    logic [31:0]  eng_q;
    logic         res_valid;
    logic         res_op;
    logic [31:0]  res_q;
    logic         res_ready;
    logic         busy;
    logic [4:0]   count;
    logic [31:0]  q_val;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    newton_iter_sched #(.ITER_CYCLES(ITER), .W(W)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .div_req    (div_req),
        .div_a      (div_a),
        .div_b      (div_b),
        .sqrt_req   (sqrt_req),
        .sqrt_d     (sqrt_d),
        .cancel     (cancel),
        .div_ack    (div_ack),
        .sqrt_ack   (sqrt_ack),
        .div_stall  (div_stall),
        .sqrt_stall (sqrt_stall),
        .eng_start  (eng_start),
        .eng_op     (eng_op),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_q      (eng_q),
        .res_valid  (res_valid),
        .res_op     (res_op),
        .res_q      (res_q),
        .res_ready  (res_ready),
        .busy       (busy),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The engine output is only meaningful at the last iteration; elsewhere it is junk.
    assign eng_q = (count == 5'(ITER)) ? q_val : (32'hBAD0_0000 | 32'(count));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since grant, pending result, and who gets priority on a tie.
    int          m_t   = 0;
    bit          m_rv  = 0;
    bit          m_ptr = 0;
    bit          m_op  = 0;
    bit          m_rop = 0;
    logic [W-1:0] m_a  = '0;
    logic [W-1:0] m_b  = '0;
    logic [31:0] m_rq  = '0;

    function automatic bit m_idle();
        return (m_t == 0) && !m_rv;
    endfunction

    function automatic bit exp_dack();
        return m_idle() && !cancel && !clrn && div_req && (!sqrt_req || !m_ptr);
    endfunction

    function automatic bit exp_sack();
        return m_idle() && !cancel && !clrn && sqrt_req && (!div_req || m_ptr);
    endfunction

    always @(posedge clk) begin
        bit gd;
        bit gs;
        gd = exp_dack();
        gs = exp_sack();
        if (clrn) begin
            m_t = 0; m_rv = 0; m_ptr = 0; m_op = 0; m_rop = 0;
            m_a = '0; m_b = '0; m_rq = '0;
        end else if (m_idle()) begin
            if (gd || gs) begin
                m_op = gs;
                m_a  = gs ? sqrt_d : div_a;
                m_b  = gs ? '0 : div_b;
                m_t  = 1;
            end
        end else if (m_t != 0) begin
            if (cancel) begin
                m_t = 0;
            end else if (m_t == ITER) begin
                m_rq  = eng_q;
                m_rop = m_op;
                m_rv  = 1;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end else begin
            if (cancel) begin
                m_rv = 0;
            end else if (res_ready) begin
                m_rv  = 0;
                m_ptr = !m_op;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit eb;
            eb = (m_t != 0) || m_rv;
            chk("div_ack",    32'(div_ack),    32'(exp_dack()));
            chk("sqrt_ack",   32'(sqrt_ack),   32'(exp_sack()));
            chk("div_stall",  32'(div_stall),  32'((div_req && !exp_dack()) || (eb && !m_op)));
            chk("sqrt_stall", 32'(sqrt_stall), 32'((sqrt_req && !exp_sack()) || (eb && m_op)));
            chk("eng_start",  32'(eng_start),  32'(m_t == 1));
            chk("eng_op",     32'(eng_op),     32'(m_op));
            chk("eng_a",      32'(eng_a),      32'(m_a));
            chk("eng_b",      32'(eng_b),      32'(m_b));
            chk("res_valid",  32'(res_valid),  32'(m_rv));
            chk("res_op",     32'(res_op),     32'(m_rop));
            chk("res_q",      res_q,           m_rq);
            chk("busy",       32'(busy),       32'(eb));
            chk("count",      32'(count),      32'(m_t));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_done();
        int k;
        k = 0;
        while (!res_valid && k < 40) begin
            tick();
            k++;
        end
        chk("done_reached", 32'(res_valid), 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        clrn = 1'b1; div_req = 1'b0; sqrt_req = 1'b0; cancel = 1'b0; res_ready = 1'b0;
        div_a = '0; div_b = '0; sqrt_d = '0; q_val = '0;
        tick();
        chk_en = 1;
        tick();
        clrn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_res_q", res_q, 32'd0);

        // Single sqrt with the reference operand and result.
        sqrt_req = 1'b1; sqrt_d = 24'hC00000; q_val = 32'hDDB3D743;
        #1;
        chk("t1_sqrt_ack", 32'(sqrt_ack), 32'd1);
        chk("t1_div_ack", 32'(div_ack), 32'd0);
        tick();
        sqrt_req = 1'b0;
        #1;
        chk("t1_start", 32'(eng_start), 32'd1);
        chk("t1_op", 32'(eng_op), 32'd1);
        chk("t1_a", 32'(eng_a), 32'h00C00000);
        chk("t1_b", 32'(eng_b), 32'd0);
        tick();
        chk("t1_start_gone", 32'(eng_start), 32'd0);
        repeat (20) tick();
        chk("t1_count22", 32'(count), 32'd22);
        chk("t1_not_yet", 32'(res_valid), 32'd0);
        tick();
        chk("t1_valid_at_23", 32'(res_valid), 32'd1);
        chk("t1_res_q", res_q, 32'hDDB3D743);
        chk("t1_res_op", 32'(res_op), 32'd1);
        accept();
        chk("t1_released", 32'(res_valid), 32'd0);

        // Tie after a sqrt completion: pointer points at divide.
        div_req = 1'b1; sqrt_req = 1'b1; div_a = 24'h800000; div_b = 24'hC00000; q_val = 32'h3F2AAAAB;
        #1;
        chk("t2_div_wins", 32'(div_ack), 32'd1);
        chk("t2_sqrt_waits", 32'(sqrt_ack), 32'd0);
        tick();
        div_req = 1'b0;
        #1;
        chk("t2_sqrt_stall", 32'(sqrt_stall), 32'd1);
        chk("t2_eng_b", 32'(eng_b), 32'h00C00000);
        run_to_done();
        chk("t2_res_q", res_q, 32'h3F2AAAAB);
        accept();
        #1;
        chk("t2_sqrt_next", 32'(sqrt_ack), 32'd1);
        q_val = 32'h3F9CC471;
        tick();
        sqrt_req = 1'b0;
        run_to_done();
        chk("t2_sqrt_res_op", 32'(res_op), 32'd1);
        accept();
        div_req = 1'b1; sqrt_req = 1'b1; q_val = 32'h12345678;
        #1;
        chk("t2_third_tie_div", 32'(div_ack), 32'd1);
        tick();
        div_req = 1'b0; sqrt_req = 1'b0;

        // Backpressure with a new divide waiting.
        run_to_done();
        div_req = 1'b1; div_a = 24'hA00000; div_b = 24'h900000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_hold_valid", 32'(res_valid), 32'd1);
            chk("t3_hold_q", res_q, 32'h12345678);
            chk("t3_hold_op", 32'(res_op), 32'd0);
            chk("t3_div_stall", 32'(div_stall), 32'd1);
            chk("t3_no_ack", 32'(div_ack), 32'd0);
            tick();
        end
        accept();
        #1;
        chk("t3_div_acked", 32'(div_ack), 32'd1);

        // Cancel at count 10 while the requester keeps its request up.
        tick();
        repeat (9) tick();
        chk("t4_count10", 32'(count), 32'd10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        #1;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_no_valid", 32'(res_valid), 32'd0);
        chk("t4_reack", 32'(div_ack), 32'd1);
        q_val = 32'hCAFEF00D;
        tick();
        div_req = 1'b0;
        run_to_done();

        // Reset while a result is waiting.
        clrn = 1'b1;
        tick();
        clrn = 1'b0;
        #1;
        chk("t5_valid", 32'(res_valid), 32'd0);
        chk("t5_res_q", res_q, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_eng_a", 32'(eng_a), 32'd0);
        chk("t5_eng_b", 32'(eng_b), 32'd0);
        chk("t5_eng_start", 32'(eng_start), 32'd0);

        // Pointer back at divide after reset, then cancel and accept in the same DONE cycle.
        div_req = 1'b1; sqrt_req = 1'b1; sqrt_d = 24'hE00000; q_val = 32'h01020304;
        #1;
        chk("t6_div_after_rst", 32'(div_ack), 32'd1);
        tick();
        div_req = 1'b0;
        run_to_done();
        cancel = 1'b1; res_ready = 1'b1;
        tick();
        cancel = 1'b0; res_ready = 1'b0; div_req = 1'b1;
        #1;
        chk("t6_dropped", 32'(res_valid), 32'd0);
        chk("t6_div_again", 32'(div_ack), 32'd1);
        chk("t6_sqrt_waits", 32'(sqrt_ack), 32'd0);
        tick();
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        #1;
        chk("t6_run_cancel_ptr", 32'(div_ack), 32'd1);
        tick();
        div_req = 1'b0; sqrt_req = 1'b0;
        run_to_done();
        accept();
        tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/newton_iter_sched.md
Name: newton_iter_sched

Overview:
- Scheduler that shares one iterative Newton-Raphson engine (fdiv / fsqrt, 24-bit mantissa path) between the divide and square-root requesters of the FP pipeline.
- Arbitrates simultaneous requests round-robin and latches the winner's operands.
- Issues a one-cycle start to the engine, times the fixed iteration latency, and captures the 32-bit result.
- Holds the result under a valid/ready handshake until writeback accepts it. Drives per-requester stall so the ID stage freezes while the engine is occupied.

Parameters:
- ITER_CYCLES, 22, cycles from eng_start to a valid eng_q (legal range 2..31).
- W, 24, operand mantissa width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- clrn  input  1  reset. Synchronous, active-high: clrn=1 at a posedge resets the block.
- div_req  input  1  divide request; held until div_ack.
- div_a  input  W  dividend mantissa.
- div_b  input  W  divisor mantissa.
- sqrt_req  input  1  sqrt request; held until sqrt_ack.
- sqrt_d  input  W  radicand mantissa.
- cancel  input  1  pipeline flush; aborts the in-flight operation.
- div_ack  output  1  one-cycle grant pulse to the divide requester.
- sqrt_ack  output  1  one-cycle grant pulse to the sqrt requester.
- div_stall  output  1  the divide requester must hold.
- sqrt_stall  output  1  the sqrt requester must hold.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_op  output  1  0 = divide, 1 = sqrt; stable from eng_start until return to IDLE.
- eng_a  output  W  registered operand a (div_a or sqrt_d).
- eng_b  output  W  registered operand b (div_b, or 0 for sqrt).
- eng_q  input  32  engine result; sampled only at the capture cycle.
- res_valid  output  1  result available.
- res_op  output  1  op that produced res_q.
- res_q  output  32  captured result.
- res_ready  input  1  writeback accepts the result.
- busy  output  1  state != IDLE.
- count  output  5  iteration counter (debug/sim).

Behaviour:
- States: IDLE, RUN, DONE.
- Reset values: all outputs 0, state IDLE, count 0, priority pointer = DIV.
- IDLE, grant rules:
  - No grant when cancel=1.
  - Otherwise grant if div_req or sqrt_req. If both are asserted, the requester named by the priority pointer wins.
  - Grant cycle: combinational ack pulse for the winner.
  - Next edge: latch operands into eng_a/eng_b, set eng_op and eng_start=1, count<=1, state<=RUN.
- RUN:
  - eng_start is 1 only in the first RUN cycle.
  - count increments each cycle.
  - At count==ITER_CYCLES: res_q<=eng_q, res_op<=eng_op, res_valid<=1, count<=0, state<=DONE.
  - Total latency from ack edge to res_valid = ITER_CYCLES+1 cycles.
- DONE:
  - res_valid, res_q and res_op are held stable while res_ready=0.
  - On res_ready=1: res_valid<=0, priority pointer <= the other op, state<=IDLE.
  - A new grant is possible only in the following IDLE cycle (one-bubble turnaround).
- Stall logic:
  - div_stall = div_req & ~div_ack, OR (busy & eng_op==0) until res accepted; sqrt_stall symmetric.
  - A request arriving while busy is not acked; it stalls and is arbitrated at the next IDLE.
- cancel in RUN or DONE: next edge state<=IDLE, count<=0, res_valid<=0, eng_start<=0. Priority pointer unchanged; the result is discarded.
- cancel and res_ready in the same DONE cycle: cancel wins, and the priority pointer is unchanged.
- Reset mid-operation: returns to reset values on the next edge, regardless of state.
- A request dropped before ack is simply not served. There is no memory of unacked requests.
- eng_b for sqrt is driven 0.

Decomposition:
- Shared FP-unit package holds:
  - op encoding constants OP_DIV=0, OP_SQRT=1;
  - state encoding IDLE/RUN/DONE;
  - the default ITER_CYCLES=22, shared with the Newton divide/sqrt units so the latency matches the engine's 3-iteration × 7-cycle schedule.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with pointer-update enable.
- Counter and handshake logic stay in newton_iter_sched.

Test Plan:
- Single sqrt:
  - Stimulus: sqrt_req=1, sqrt_d=24'hC00000.
  - Required: sqrt_ack in the first cycle; eng_start one cycle later with eng_op=1, eng_a=C00000, eng_b=0.
  - With eng_q=32'hDDB3D743 at count 22, res_valid rises 23 cycles after ack and res_q=DDB3D743.
- Simultaneous requests after reset:
  - Stimulus: div_req and sqrt_req both held.
  - Required: div granted first.
  - After res_ready, sqrt is granted in the second IDLE cycle.
  - On the third tie, div wins again (pointer alternates).
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in DONE.
  - Required: res_valid=1 and res_q/res_op stable throughout.
  - div_stall stays 1 for a pending div_req; no ack until after res_ready.
- Cancel at count=10 in RUN:
  - Required: IDLE next cycle, res_valid never asserts, priority pointer unchanged.
  - A held req is re-acked on the following cycle.
- Reset mid-DONE:
  - Stimulus: clrn=1 for one edge while res_valid=1.
  - Required: all outputs 0 after that edge; the priority pointer returns to DIV.
- cancel + res_ready in the same DONE cycle:
  - Required: result dropped and priority not toggled. A following tie is won by the same op as before.
